// File: rtl/wb_upsizer.sv
// Pipelined Wishbone bus-width upsizer: narrow slave port in, wide master port out.
// Each narrow beat becomes one wide beat on the lane chosen by the low address bits (lane 0 = MSBs).
module wb_upsizer #(
    parameter int DWIN = 32,
    parameter int DWOUT = 128,
    parameter int AW = 30,
    parameter int LGFIFO = 4,
    localparam int LGR = $clog2(DWOUT / DWIN)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_s_cyc,
    input  logic                  i_s_stb,
    input  logic                  i_s_we,
    input  logic [AW-1:0]         i_s_addr,
    input  logic [DWIN-1:0]       i_s_data,
    input  logic [DWIN/8-1:0]     i_s_sel,
    output logic                  o_s_stall,
    output logic                  o_s_ack,
    output logic                  o_s_err,
    output logic [DWIN-1:0]       o_s_data,
    output logic                  o_m_cyc,
    output logic                  o_m_stb,
    output logic                  o_m_we,
    output logic [AW-LGR-1:0]     o_m_addr,
    output logic [DWOUT-1:0]      o_m_data,
    output logic [DWOUT/8-1:0]    o_m_sel,
    input  logic                  i_m_stall,
    input  logic                  i_m_ack,
    input  logic                  i_m_err,
    input  logic [DWOUT-1:0]      i_m_data
);
    localparam int LW = (LGR > 0) ? LGR : 1;
    localparam int LGDW = $clog2(DWIN);
    localparam int SW = LW + LGDW;
    localparam int SELW = DWOUT / 8;
    localparam int DEPTH = 1 << LGFIFO;
    localparam logic [LGFIFO:0] FULL_CNT = {1'b1, {LGFIFO{1'b0}}};

    logic                  r_m_cyc, r_m_stb, r_m_we;
    logic [AW-LGR-1:0]     r_m_addr;
    logic [DWOUT-1:0]      r_m_data;
    logic [SELW-1:0]       r_m_sel;

    logic                  r_skid_valid, r_skid_we;
    logic [AW-LGR-1:0]     r_skid_addr;
    logic [DWOUT-1:0]      r_skid_data;
    logic [SELW-1:0]       r_skid_sel;

    logic [LGFIFO:0]       r_out, r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]         r_fifo [DEPTH];
    logic                  r_abort;
    logic                  r_s_ack, r_s_err;
    logic [DWIN-1:0]       r_s_data;

    logic [LW-1:0]         w_lane, w_rlane, w_head_rlane;
    logic [SW-1:0]         w_dshift, w_sshift, w_rshift;
    logic [DWOUT-1:0]      w_new_data, w_rd_lane;
    logic [SELW-1:0]       w_new_sel;
    logic [AW-LGR-1:0]     w_new_addr;
    logic                  w_stall, w_accept, w_err, w_flush, w_ack, w_m_hold, w_fifo_ne;

    // Lane 0 sits in the MSBs, so the shift distance uses the inverted lane index.
    if (LGR > 0) begin : g_lanes
        assign w_lane       = i_s_addr[LW-1:0];
        assign w_rlane      = ~w_lane;
        assign w_head_rlane = ~r_fifo[r_rd_ptr[LGFIFO-1:0]];
    end else begin : g_pass
        assign w_lane       = '0;
        assign w_rlane      = '0;
        assign w_head_rlane = '0;
    end

    assign w_dshift   = SW'(w_rlane) << LGDW;
    assign w_sshift   = SW'(w_rlane) << (LGDW - 3);
    assign w_rshift   = SW'(w_head_rlane) << LGDW;
    assign w_new_data = DWOUT'(i_s_data) << w_dshift;
    assign w_new_sel  = SELW'(i_s_sel) << w_sshift;
    assign w_new_addr = i_s_addr[AW-1:LGR];
    assign w_rd_lane  = i_m_data >> w_rshift;

    assign w_stall   = r_skid_valid | (r_out == FULL_CNT) | r_abort;
    assign w_accept  = i_s_cyc & i_s_stb & ~w_stall;
    assign w_err     = i_m_err & r_m_cyc;
    assign w_flush   = w_err | ~i_s_cyc;
    assign w_fifo_ne = (r_wr_ptr != r_rd_ptr);
    assign w_ack     = i_m_ack & r_m_cyc & ~r_abort & ~w_flush & w_fifo_ne;
    assign w_m_hold  = r_m_stb & i_m_stall;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_m_stb      <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_addr     <= '0;
            r_m_data     <= '0;
            r_m_sel      <= '0;
            r_skid_valid <= 1'b0;
            r_skid_we    <= 1'b0;
            r_skid_addr  <= '0;
            r_skid_data  <= '0;
            r_skid_sel   <= '0;
        end else if (w_flush) begin
            r_m_stb      <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!w_m_hold) begin
            if (r_skid_valid) begin
                r_m_stb      <= 1'b1;
                r_m_we       <= r_skid_we;
                r_m_addr     <= r_skid_addr;
                r_m_data     <= r_skid_data;
                r_m_sel      <= r_skid_sel;
                r_skid_valid <= 1'b0;
            end else begin
                r_m_stb <= w_accept;
                if (w_accept) begin
                    r_m_we   <= i_s_we;
                    r_m_addr <= w_new_addr;
                    r_m_data <= w_new_data;
                    r_m_sel  <= w_new_sel;
                end
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_we    <= i_s_we;
            r_skid_addr  <= w_new_addr;
            r_skid_data  <= w_new_data;
            r_skid_sel   <= w_new_sel;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_m_cyc  <= 1'b0;
            r_abort  <= 1'b0;
            r_out    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_s_ack  <= 1'b0;
            r_s_err  <= 1'b0;
            r_s_data <= '0;
        end else begin
            r_m_cyc <= i_s_cyc & ~w_err & ~r_abort;
            r_s_ack <= w_ack;
            r_s_err <= w_err & i_s_cyc;
            if (w_ack)
                r_s_data <= w_rd_lane[DWIN-1:0];
            if (!i_s_cyc)
                r_abort <= 1'b0;
            else if (w_err)
                r_abort <= 1'b1;
            if (w_flush) begin
                r_out    <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                // Outstanding counts until the slave sees its ack, so it lags the FIFO pop by one clock.
                case ({w_accept, r_s_ack})
                    2'b10:   r_out <= r_out + 1'b1;
                    2'b01:   r_out <= r_out - 1'b1;
                    default: r_out <= r_out;
                endcase
                if (w_accept)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_ack)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept && !w_flush)
            r_fifo[r_wr_ptr[LGFIFO-1:0]] <= w_lane;
    end

    assign o_s_stall = w_stall;
    assign o_s_ack   = r_s_ack & i_s_cyc;
    assign o_s_err   = r_s_err & i_s_cyc;
    assign o_s_data  = r_s_data;
    assign o_m_cyc   = r_m_cyc;
    assign o_m_stb   = r_m_stb;
    assign o_m_we    = r_m_we;
    assign o_m_addr  = r_m_addr;
    assign o_m_data  = r_m_data;
    assign o_m_sel   = r_m_sel;

endmodule
